// File: rtl/lfsr_rewind.sv
// lfsr_rewind
// Sequential inverse stepper for the 8-bit Fibonacci LFSR in npc. Forward
// step is {s[4]^s[3]^s[2]^s[0], s[7:1]}. Given a state and a step count N,
// the block walks the register backwards one inverse step per clock and
// presents the state N forward steps earlier.
//
// Ports:
//   clk        in   single clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   request present
//   in_ready   out  block can accept a request (IDLE only)
//   in_state   in   8-bit LFSR state to rewind from
//   in_steps   in   CNT_W-bit number of inverse steps
//   out_valid  out  result present (DONE only)
//   out_ready  in   consumer takes the result
//   out_state  out  8-bit state after N inverse steps
//   busy       out  high whenever the FSM is not in IDLE
module lfsr_rewind #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_state,
  input  logic [CNT_W-1:0] in_steps,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_state,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } fsm_t;

  fsm_t             fsm;
  fsm_t             fsm_next;
  logic [7:0]       st;
  logic [7:0]       st_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;

  // Inverse of the forward step: the bit shifted out at the bottom is
  // recovered from the feedback bit (now at the top) and the surviving taps.
  function automatic logic [7:0] prev_state(input logic [7:0] n);
    return {n[6:0], n[7] ^ n[3] ^ n[2] ^ n[1]};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm <= IDLE;
      st  <= 8'h00;
      cnt <= '0;
    end else begin
      fsm <= fsm_next;
      st  <= st_next;
      cnt <= cnt_next;
    end
  end

  // RUN is only entered with a nonzero count, so the decrement never wraps;
  // the last step is taken on the edge where cnt is 1.
  always_comb begin
    fsm_next  = fsm;
    st_next   = st;
    cnt_next  = cnt;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (fsm)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          st_next  = in_state;
          cnt_next = in_steps;
          fsm_next = (in_steps != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        st_next  = prev_state(st);
        cnt_next = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          fsm_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          fsm_next = IDLE;
        end
      end
      default: begin
        fsm_next = IDLE;
      end
    endcase
  end

  assign out_state = st;
  assign busy      = (fsm != IDLE);

endmodule

// File: tb/tb_lfsr_rewind.sv
// tb_lfsr_rewind
// Directed self-checking bench for lfsr_rewind: reset state, short known
// vectors, zero-step and max-step requests, round trips through a forward
// LFSR model, backpressure hold, and asynchronous reset in the middle of RUN.
module tb_lfsr_rewind;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_state;
  logic [7:0] in_steps;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_state;
  logic       busy;

  int checks;
  int failures;

  lfsr_rewind #(.CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .in_steps  (in_steps),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Forward LFSR step used as the reference model for round trips.
  function automatic logic [7:0] fwd(input logic [7:0] s);
    return {s[4] ^ s[3] ^ s[2] ^ s[0], s[7:1]};
  endfunction

  // One comparison: counts it, and on mismatch counts and reports it.
  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Presents a request, then counts edges after the accept edge until
  // out_valid rises (bounded so a stuck design still reaches the summary).
  // Request inputs are scrambled after acceptance to show they are ignored.
  task automatic apply_stimulus(input logic [7:0] s, input logic [7:0] n,
                                output logic [7:0] res, output int edges);
    @(negedge clk);
    check_output("accept_in_ready", {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_state = s;
    in_steps = n;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_state = 8'hFF;
    in_steps = 8'hFF;
    edges = 0;
    while (!out_valid && edges < 300) begin
      @(posedge clk);
      #1;
      edges++;
    end
    res = out_state;
  endtask

  // Consumes the pending result and confirms the return to IDLE.
  task automatic release_result(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_output({tag, "_valid_drop"}, {31'b0, out_valid}, 32'd0);
    check_output({tag, "_idle_ready"}, {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    logic [7:0] res;
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] n;
    int         edges;

    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_state  = 8'h00;
    in_steps  = 8'h00;
    out_ready = 1'b0;

    // Reset state
    #1;
    check_output("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check_output("rst_busy", {31'b0, busy}, 32'd0);
    check_output("rst_out_state", {24'b0, out_state}, 32'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // 0x01 / 1 -> 0x02
    apply_stimulus(8'h01, 8'd1, res, edges);
    check_output("v1_edges", edges, 32'd1);
    check_output("v1_state", {24'b0, res}, 32'h02);
    check_output("v1_busy", {31'b0, busy}, 32'd1);
    release_result("v1");

    // 0x80 / 2 -> 0x01 -> 0x02
    apply_stimulus(8'h80, 8'd2, res, edges);
    check_output("v2_edges", edges, 32'd2);
    check_output("v2_state", {24'b0, res}, 32'h02);
    release_result("v2");

    // Zero steps: state passes through the cycle after accept
    apply_stimulus(8'hA5, 8'd0, res, edges);
    check_output("n0_edges", edges, 32'd0);
    check_output("n0_state", {24'b0, res}, 32'hA5);
    release_result("n0");

    // All-zero state is a fixed point
    apply_stimulus(8'h00, 8'd200, res, edges);
    check_output("zero_edges", edges, 32'd200);
    check_output("zero_state", {24'b0, res}, 32'h00);
    release_result("zero");

    // Max count, checked via forward model
    apply_stimulus(8'h5A, 8'd255, res, edges);
    check_output("max_edges", edges, 32'd255);
    y = res;
    for (int i = 0; i < 255; i++) y = fwd(y);
    check_output("max_roundtrip", {24'b0, y}, 32'h5A);
    release_result("max");

    // Random round trips
    for (int k = 0; k < 3; k++) begin
      x = 8'($urandom_range(1, 255));
      n = 8'($urandom_range(1, 255));
      apply_stimulus(x, n, res, edges);
      check_output("rt_edges", edges, {24'b0, n});
      y = res;
      for (int i = 0; i < int'(n); i++) y = fwd(y);
      check_output("rt_state", {24'b0, y}, {24'b0, x});
      release_result("rt");
    end

    // Backpressure: 0x0F / 1 -> 0x1F held for 10 cycles with in_valid high
    apply_stimulus(8'h0F, 8'd1, res, edges);
    check_output("bp_edges", edges, 32'd1);
    check_output("bp_state", {24'b0, res}, 32'h1F);
    in_valid = 1'b1;
    in_state = 8'h01;
    in_steps = 8'd1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check_output("bp_hold_valid", {31'b0, out_valid}, 32'd1);
      check_output("bp_hold_state", {24'b0, out_state}, 32'h1F);
      check_output("bp_hold_ready", {31'b0, in_ready}, 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_output("bp_rel_valid", {31'b0, out_valid}, 32'd0);
    check_output("bp_rel_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_output("bp_next_accept", {31'b0, busy}, 32'd1);
    edges = 0;
    while (!out_valid && edges < 300) begin
      @(posedge clk);
      #1;
      edges++;
    end
    check_output("bp_next_edges", edges, 32'd1);
    check_output("bp_next_state", {24'b0, out_state}, 32'h02);
    release_result("bp");

    // Asynchronous reset at step 40 of a 100-step request
    @(negedge clk);
    in_valid = 1'b1;
    in_state = 8'h01;
    in_steps = 8'd100;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check_output("mid_busy", {31'b0, busy}, 32'd1);
    check_output("mid_valid", {31'b0, out_valid}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("arst_valid", {31'b0, out_valid}, 32'd0);
    check_output("arst_busy", {31'b0, busy}, 32'd0);
    check_output("arst_state", {24'b0, out_state}, 32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    apply_stimulus(8'h01, 8'd1, res, edges);
    check_output("post_rst_edges", edges, 32'd1);
    check_output("post_rst_state", {24'b0, res}, 32'h02);
    release_result("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
